// File: rtl/keycode_pkg.sv
// Shared constants and FSM encoding for the keycode writer and its slot bank.
// Optional macro handled elsewhere: KEYCODE_ROLLOVER_ERR_EN.
package keycode_pkg;

  localparam int CODE_W = 8;

  localparam logic [CODE_W-1:0] KEY_NONE     = 8'h00;
  localparam logic [CODE_W-1:0] KEY_ROLLOVER = 8'h01;

  localparam logic [CODE_W-1:0] KEY_W = 8'h1A;
  localparam logic [CODE_W-1:0] KEY_A = 8'h04;
  localparam logic [CODE_W-1:0] KEY_S = 8'h16;
  localparam logic [CODE_W-1:0] KEY_D = 8'h07;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    UPDATE
  } state_t;

endpackage

// File: rtl/keycode_if.sv
// Keycode bus: event handshake from the key source plus the packed held-key report.
// The master drives events; the slave (keycode_writer) publishes the report.
import keycode_pkg::*;

interface keycode_if #(
  parameter int NUM_SLOTS = 4,
  parameter int CODE_W    = keycode_pkg::CODE_W
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic                        ev_valid;
  logic                        ev_ready;
  logic                        ev_press;
  logic [CODE_W-1:0]           ev_code;
  logic [NUM_SLOTS*CODE_W-1:0] keycode;
  logic [CNT_W-1:0]            key_count;
  logic                        report_valid;
  logic                        dropped;

  modport master (
    output ev_valid, ev_press, ev_code,
    input  ev_ready, keycode, key_count, report_valid, dropped
  );

  modport slave (
    input  ev_valid, ev_press, ev_code,
    output ev_ready, keycode, key_count, report_valid, dropped
  );

endinterface

// File: rtl/keycode_slot_bank.sv
// Ordered storage of held usage codes: indexed read, append at the tail and
// remove-with-shift-down so occupied slots stay contiguous from slot 0.
import keycode_pkg::*;

module keycode_slot_bank #(
  parameter int NUM_SLOTS = 4,
  parameter int CODE_W    = keycode_pkg::CODE_W,
  parameter int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [IDX_W-1:0]            i_rd_idx,
  output logic [CODE_W-1:0]           o_rd_code,
  input  logic                        i_append,
  input  logic [CODE_W-1:0]           i_code,
  input  logic                        i_remove,
  input  logic [IDX_W-1:0]            i_rm_idx,
  output logic [CNT_W-1:0]            o_count,
  output logic [NUM_SLOTS*CODE_W-1:0] o_packed
);

  logic [CODE_W-1:0] r_slot  [NUM_SLOTS];
  logic [CODE_W-1:0] w_above [NUM_SLOTS];
  logic [CNT_W-1:0]  r_count;

  // w_above[i] is what slot i becomes when a key at or below it is removed.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    if (g < NUM_SLOTS - 1) begin : g_mid
      assign w_above[g] = r_slot[g+1];
    end else begin : g_top
      assign w_above[g] = KEY_NONE;
    end
    assign o_packed[g*CODE_W +: CODE_W] = r_slot[g];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_slot[i] <= KEY_NONE;
      r_count <= '0;
    end else if (i_append) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (CNT_W'(i) == r_count) r_slot[i] <= i_code;
      end
      r_count <= r_count + CNT_W'(1);
    end else if (i_remove) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (IDX_W'(i) >= i_rm_idx) r_slot[i] <= w_above[i];
      end
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_rd_code = r_slot[i_rd_idx];
  assign o_count   = r_count;

endmodule

// File: rtl/keycode_writer.sv
// Turns single-key press/release events into a packed multi-key keycode word.
// Build option KEYCODE_ROLLOVER_ERR_EN: overflow shows ErrorRollOver in every slot.
import keycode_pkg::*;

module keycode_writer #(
  parameter int NUM_SLOTS = 4,
  parameter int CODE_W    = keycode_pkg::CODE_W
) (
  input  logic     Clk,
  input  logic     Reset,
  keycode_if.slave kb
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  state_t r_state;
  state_t w_next;

  logic                        r_press;
  logic [CODE_W-1:0]           r_code;
  logic [IDX_W-1:0]            r_scan_idx;
  logic                        r_hit;
  logic [IDX_W-1:0]            r_hit_idx;
  logic                        r_report;
  logic                        r_dropped;
  logic                        w_accept;
  logic                        w_append;
  logic                        w_remove;
  logic                        w_drop;
  logic                        w_is_none;
  logic [CODE_W-1:0]           w_rd_code;
  logic [CNT_W-1:0]            w_count;
  logic [NUM_SLOTS*CODE_W-1:0] w_packed;

  keycode_slot_bank #(
    .NUM_SLOTS (NUM_SLOTS),
    .CODE_W    (CODE_W),
    .IDX_W     (IDX_W),
    .CNT_W     (CNT_W)
  ) u_bank (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_rd_idx  (r_scan_idx),
    .o_rd_code (w_rd_code),
    .i_append  (w_append),
    .i_code    (r_code),
    .i_remove  (w_remove),
    .i_rm_idx  (r_hit_idx),
    .o_count   (w_count),
    .o_packed  (w_packed)
  );

  assign w_accept  = kb.ev_valid && (r_state == IDLE);
  assign w_is_none = (r_code == KEY_NONE);

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_append = 1'b0;
    w_remove = 1'b0;
    w_drop   = 1'b0;
    case (r_state)
      IDLE:   if (kb.ev_valid) w_next = SCAN;
      SCAN:   if (r_scan_idx == IDX_W'(NUM_SLOTS - 1)) w_next = UPDATE;
      UPDATE: begin
        w_next = IDLE;
        // A NONE code can never hit, so only the press paths need the guard.
        if (r_press && !r_hit && !w_is_none) begin
          if (w_count < CNT_W'(NUM_SLOTS)) w_append = 1'b1;
          else                             w_drop   = 1'b1;
        end
        if (!r_press && r_hit) w_remove = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // Event holding register is pure data and needs no reset.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_press <= kb.ev_press;
      r_code  <= kb.ev_code;
    end
  end

`ifdef KEYCODE_ROLLOVER_ERR_EN
  logic r_phantom;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_scan_idx <= '0;
      r_hit      <= 1'b0;
      r_hit_idx  <= '0;
      r_report   <= 1'b0;
      r_dropped  <= 1'b0;
`ifdef KEYCODE_ROLLOVER_ERR_EN
      r_phantom  <= 1'b0;
`endif
    end else begin
      r_report  <= w_append | w_remove;
      r_dropped <= w_drop;
`ifdef KEYCODE_ROLLOVER_ERR_EN
      if (w_drop && !r_phantom) begin
        r_phantom <= 1'b1;
        r_report  <= 1'b1;
      end
      if (w_remove) r_phantom <= 1'b0;
`endif
      if (w_accept) begin
        r_scan_idx <= '0;
        r_hit      <= 1'b0;
      end else if (r_state == SCAN) begin
        if ((CNT_W'(r_scan_idx) < w_count) && (w_rd_code == r_code)) begin
          r_hit     <= 1'b1;
          r_hit_idx <= r_scan_idx;
        end
        r_scan_idx <= r_scan_idx + IDX_W'(1);
      end
    end
  end

  assign kb.ev_ready     = (r_state == IDLE);
  assign kb.key_count    = w_count;
  assign kb.report_valid = r_report;
  assign kb.dropped      = r_dropped;

`ifdef KEYCODE_ROLLOVER_ERR_EN
  assign kb.keycode = r_phantom ? {NUM_SLOTS{KEY_ROLLOVER}} : w_packed;
`else
  assign kb.keycode = w_packed;
`endif

endmodule

// File: tb/tb_keycode_writer.sv
// Directed and randomized bench for keycode_writer against a queue-based model of the held-key set.
module tb_keycode_writer;

  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] held[$];
  bit         phantom = 1'b0;

  always #5 clk = ~clk;

  keycode_if #(.NUM_SLOTS(NS)) kif();

  keycode_writer #(.NUM_SLOTS(NS)) dut (
    .Clk   (clk),
    .Reset (rst),
    .kb    (kif)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < NS; i++) if (i < held.size()) w[i*8 +: 8] = held[i];
`ifdef KEYCODE_ROLLOVER_ERR_EN
    if (phantom) w = 32'h01010101;
`endif
    return w;
  endfunction

  task automatic model_apply(input bit press, input logic [7:0] code, output bit rep, output bit drp);
    int idx;
    rep = 0; drp = 0; idx = -1;
    for (int i = 0; i < held.size(); i++) if (held[i] == code) idx = i;
    if (code == 8'h00) begin
      // no effect
    end else if (press) begin
      if (idx < 0) begin
        if (held.size() < NS) begin
          held.push_back(code);
          rep = 1;
        end else begin
          drp = 1;
`ifdef KEYCODE_ROLLOVER_ERR_EN
          if (!phantom) rep = 1;
          phantom = 1;
`endif
        end
      end
    end else if (idx >= 0) begin
      held.delete(idx);
      rep = 1;
      phantom = 0;
    end
  endtask

  task automatic do_event(input bit press, input logic [7:0] code, input bit hold);
    int n, low, early;
    bit er, ed;
    n = 0;
    while (kif.ev_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 20), 32'd1);
    kif.ev_valid = 1'b1;
    kif.ev_press = press;
    kif.ev_code  = code;
    @(posedge clk);
    low = 0; early = 0;
    for (int c = 1; c <= NS + 1; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) kif.ev_valid = 1'b0;
      if (kif.ev_ready === 1'b0) low++;
      if (kif.report_valid !== 1'b0 || kif.dropped !== 1'b0) early++;
    end
    @(negedge clk);
    model_apply(press, code, er, ed);
    chk("busy_cycles", low, NS + 1);
    chk("early_pulse", early, 0);
    chk("ready_back", 32'(kif.ev_ready), 32'd1);
    chk("report_valid", 32'(kif.report_valid), 32'(er));
    chk("dropped", 32'(kif.dropped), 32'(ed));
    chk("keycode", kif.keycode, model_word());
    chk("key_count", 32'(kif.key_count), held.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    kif.ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    held.delete();
    phantom = 0;
  endtask

  initial begin
    logic [7:0] pool [8];
    int pulses;
    pool = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h05, 8'h00, 8'h1A};
    kif.ev_valid = 1'b0;
    kif.ev_press = 1'b0;
    kif.ev_code  = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_keycode", kif.keycode, 32'h0);
    chk("rst_count", 32'(kif.key_count), 32'd0);
    chk("rst_report", 32'(kif.report_valid), 32'd0);
    chk("rst_dropped", 32'(kif.dropped), 32'd0);
    chk("rst_ready", 32'(kif.ev_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    do_event(1'b1, 8'h1A, 1'b0);
    chk("first_press", kif.keycode, 32'h0000001A);
    do_reset();

    do_event(1'b1, 8'h1A, 1'b1);
    do_event(1'b1, 8'h04, 1'b1);
    do_event(1'b1, 8'h16, 1'b1);
    do_event(1'b1, 8'h07, 1'b0);
    chk("full_word", kif.keycode, 32'h0716041A);
    chk("full_count", 32'(kif.key_count), 32'd4);

    do_event(1'b0, 8'h04, 1'b0);
    chk("release_mid", kif.keycode, 32'h0007161A);
    @(negedge clk);
    chk("report_one_cycle", 32'(kif.report_valid), 32'd0);

    do_reset();
    do_event(1'b1, 8'h1A, 1'b1);
    do_event(1'b1, 8'h04, 1'b1);
    do_event(1'b1, 8'h16, 1'b1);
    do_event(1'b1, 8'h07, 1'b0);
    do_event(1'b1, 8'h2C, 1'b0);
    @(negedge clk);
    chk("drop_one_cycle", 32'(kif.dropped), 32'd0);
`ifdef KEYCODE_ROLLOVER_ERR_EN
    chk("overflow_word", kif.keycode, 32'h01010101);
`else
    chk("overflow_word", kif.keycode, 32'h0716041A);
`endif
    do_event(1'b0, 8'h1A, 1'b0);
    chk("after_release", kif.keycode, 32'h00071604);

    do_event(1'b1, 8'h16, 1'b0);
    do_event(1'b0, 8'h05, 1'b0);
    do_event(1'b1, 8'h00, 1'b0);
    chk("noop_word", kif.keycode, 32'h00071604);

    // Reset landing in the middle of a scan.
    kif.ev_valid = 1'b1;
    kif.ev_press = 1'b1;
    kif.ev_code  = 8'h07;
    @(posedge clk);
    @(negedge clk);
    kif.ev_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    held.delete();
    phantom = 0;
    chk("mid_rst_keycode", kif.keycode, 32'h0);
    chk("mid_rst_count", 32'(kif.key_count), 32'd0);
    chk("mid_rst_ready", 32'(kif.ev_ready), 32'd1);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (kif.report_valid !== 1'b0) pulses++;
      @(negedge clk);
    end
    chk("mid_rst_no_report", pulses, 0);

    for (int k = 0; k < 150; k++) begin
      do_event($urandom_range(0, 2) != 0, pool[$urandom_range(0, 7)],
               (k != 149) && ($urandom_range(0, 1) == 1));
      if (kif.ev_valid === 1'b0) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    kif.ev_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keycode_writer.md
Name: keycode_writer

Overview:
- Builds the packed multi-key keycode word from a stream of single-key press/release events.
- Write side of the keycode bus: a keyboard model or host-interface bridge drives the events, and the key decoders read the packed word.
- Maintains an ordered set of up to NUM_SLOTS held USB HID usage codes.
- Slot 0 sits in bits [7:0] and holds the oldest held key; unused slots read 8'h00.
- Pulses report_valid whenever the packed word changes.

Parameters:
- NUM_SLOTS, 4, number of simultaneous keys held; keycode width is 8*NUM_SLOTS.
- CODE_W, 8, width of one usage code (fixed at 8 for HID).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- ev_valid  in  1  event present
- ev_ready  out  1  block can accept an event
- ev_press  in  1  1 = key down, 0 = key up
- ev_code  in  8  HID usage code of the event
- keycode  out  8*NUM_SLOTS  packed held-key word; slot i = bits [8i+7:8i]
- key_count  out  3  number of occupied slots (0..NUM_SLOTS)
- report_valid  out  1  one-cycle pulse when keycode changes
- dropped  out  1  one-cycle pulse when a press is discarded because all slots are full

Behaviour:
- Clock and reset: single clock Clk; Reset is synchronous and active-high.
- Reset values: keycode = 0, key_count = 0, report_valid = 0, dropped = 0, ev_ready = 1, FSM = IDLE.
- Reset asserted mid-operation aborts any scan and discards the in-flight event.
- Handshake:
  - An event is accepted on a rising Clk edge with ev_valid && ev_ready.
  - ev_press and ev_code are captured into a holding register at accept.
  - ev_ready is 1 only in IDLE.
- FSM states: IDLE -> SCAN -> UPDATE -> IDLE.
- IDLE: wait for accept; on accept go to SCAN with scan index 0.
- SCAN: one slot per cycle for NUM_SLOTS cycles, for i < key_count:
  - record hit = (slot[i] == held code) and hit_idx.
  - Unoccupied slots are never matched.
  - After index NUM_SLOTS-1, go to UPDATE.
- UPDATE (one cycle) writes registers at its closing edge, then returns to IDLE:
  - Press, no hit, key_count < NUM_SLOTS: slot[key_count] <= code; key_count += 1; report_valid next cycle.
  - Press, no hit, full: no change; dropped pulses next cycle.
  - Press, hit: no change, no pulse (duplicate press).
  - Release, hit: slots hit_idx+1..NUM_SLOTS-1 shift down one; top slot <= 8'h00; key_count -= 1; report_valid next cycle.
  - Release, no hit: no change, no pulse.
  - ev_code == 8'h00: accepted, no change, no pulse.
- Latency:
  - Accept at edge 0; SCAN occupies cycles 1..NUM_SLOTS; UPDATE is cycle NUM_SLOTS+1.
  - New keycode, report_valid and dropped are visible in cycle NUM_SLOTS+2 (cycle 6 for the default).
  - ev_ready returns high in that same cycle, so back-to-back events are accepted every NUM_SLOTS+2 cycles.
- Output timing:
  - report_valid and dropped are registered and high for exactly one cycle.
  - keycode is stable at all other times.
- Invariants: occupied slots are contiguous from slot 0 and hold no duplicate codes.

Optional Feature:
- Macro: KEYCODE_ROLLOVER_ERR_EN.
- Defined:
  - A dropped press sets a sticky phantom flag.
  - While the flag is set, keycode outputs 8'h01 (ErrorRollOver) in every slot; internal slots are unchanged.
  - report_valid pulses when the flag sets and again when it clears.
  - The flag clears on the next processed release-with-hit; the post-release real slots then appear.
  - Reset clears the flag.
- Undefined: dropped is the only indication of overflow; keycode always shows the real slots.

Decomposition:
- Shared package keycode_pkg:
  - CODE_W, KEY_NONE = 8'h00, KEY_ROLLOVER = 8'h01.
  - Movement codes: KEY_W = 8'h1A, KEY_A = 8'h04, KEY_S = 8'h16, KEY_D = 8'h07.
  - FSM enum state_t {IDLE, SCAN, UPDATE}.
- One natural sub-module, keycode_slot_bank, owns:
  - slot storage.
  - indexed read for SCAN.
  - append and shift-down-remove operations.
- The top level keeps the FSM, handshake and pulses.

Test Plan:
- Reset, then press 8'h1A -> cycle 6 after accept: keycode = 32'h0000001A, key_count = 1, report_valid for one cycle.
- Press 1A, 04, 16, 07 back-to-back with ev_valid held high -> ev_ready low 5 cycles per event; final keycode = 32'h0716041A, key_count = 4.
- From full state 32'h0716041A, release 8'h04 -> keycode = 32'h0007161A, key_count = 3, single report_valid.
- From full state, press 8'h2C -> dropped pulse, no report_valid, keycode unchanged; with KEYCODE_ROLLOVER_ERR_EN: keycode = 32'h01010101, then release 8'h1A -> 32'h00071604.
- Duplicate press 1A when 1A is held, release of absent 8'h05, and press 8'h00 -> no change, no pulses, each accepted.
- Assert Reset during SCAN of a press 8'h07 -> keycode = 0, key_count = 0, ev_ready = 1 next cycle, no report_valid.
